osc_cfg_sequencer: RTL and testbench

- Upstream command source for the byte-level I2C write engine that programs the pixel-clock oscillator (7-bit slave 0x55).
- Holds the 11-entry oscillator register table and runs the power-on wait.
- Issues one write transaction per table entry, retries NACKed or timed-out writes, then waits a settle time and asserts DDS_START so the downstream video/DDS logic can start.

---
 rtl/osc_cfg_sequencer.sv | 171 +++++++++++++++++
 tb/tb_osc_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_cfg_sequencer.sv
// Power-on sequencer for the pixel-clock oscillator: waits for power-up, then writes the
// 11-entry register table through the byte-level I2C write engine with retry, settles, and starts DDS.
module osc_cfg_sequencer #(
  parameter int unsigned POWER_ON_DELAY = 90000000,
  parameter int unsigned SETTLE_DELAY   = 150000000,
  parameter int unsigned RETRY_GAP      = 4000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RESP_TIMEOUT   = 20000,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h55
) (
  input  logic       CLOCK_IN,
  input  logic       RESET,
  output logic       WR_REQ,
  output logic [6:0] WR_SLAVE,
  output logic [7:0] WR_REG,
  output logic [7:0] WR_DATA,
  input  logic       WR_BUSY,
  input  logic       WR_DONE,
  input  logic       WR_NACK,
  output logic [3:0] STEP,
  output logic       CFG_DONE,
  output logic       CFG_FAIL,
  output logic       DDS_START
);

  typedef enum logic [2:0] {
    S_POWER_WAIT,
    S_ISSUE,
    S_WAIT_RESP,
    S_GAP,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);
  localparam logic [3:0]  LAST_STEP    = 4'd10;
  // Terminal counts; a zero-cycle setting degenerates to a one-cycle stay.
  localparam logic [31:0] POWER_LAST   = (POWER_ON_DELAY == 0) ? 32'd0 : 32'(POWER_ON_DELAY - 1);
  localparam logic [31:0] SETTLE_LAST  = (SETTLE_DELAY == 0)   ? 32'd0 : 32'(SETTLE_DELAY - 1);
  localparam logic [31:0] GAP_LAST     = (RETRY_GAP == 0)      ? 32'd0 : 32'(RETRY_GAP - 1);
  localparam logic [31:0] TIMEOUT_LAST = (RESP_TIMEOUT == 0)   ? 32'd0 : 32'(RESP_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    step_q, step_d;
  logic          wr_req_q, wr_req_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_fail_q, cfg_fail_d;
  logic          dds_start_q, dds_start_d;
  logic [15:0]   entry;
  logic          entry_active;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h8400;
      4'd1:    return 16'h0033;
      4'd2:    return 16'h05E4;
      4'd3:    return 16'h06D1;
      4'd4:    return 16'h07DF;
      4'd5:    return 16'h0896;
      4'd6:    return 16'h0908;
      4'd7:    return 16'h0A1E;
      4'd8:    return 16'h0B00;
      4'd9:    return 16'h8401;
      4'd10:   return 16'h8404;
      default: return 16'h0000;
    endcase
  endfunction

  // Table bytes are only presented while a write is pending so the bus reads zero at reset.
  always_comb begin
    entry        = table_entry(step_q);
    entry_active = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP) || (state_q == S_GAP);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = 32'd0;
    retry_d     = retry_q;
    step_d      = step_q;
    wr_req_d    = 1'b0;
    cfg_done_d  = cfg_done_q;
    cfg_fail_d  = cfg_fail_q;
    dds_start_d = dds_start_q;
    case (state_q)
      S_POWER_WAIT: begin
        if (cnt_q >= POWER_LAST) state_d = S_ISSUE;
        else                     cnt_d   = cnt_q + 32'd1;
      end
      S_ISSUE: begin
        if (!WR_BUSY) begin
          wr_req_d = 1'b1;
          state_d  = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (WR_DONE) begin
          retry_d = '0;
          if (step_q == LAST_STEP) begin
            step_d     = LAST_STEP + 4'd1;
            cfg_done_d = 1'b1;
            state_d    = S_SETTLE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (WR_NACK || (cnt_q >= TIMEOUT_LAST)) begin
          if (retry_q < MAX_RETRY_W) begin
            retry_d = retry_q + RW'(1);
            state_d = S_GAP;
          end else begin
            cfg_fail_d = 1'b1;
            state_d    = S_FAIL;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q >= GAP_LAST) state_d = S_ISSUE;
        else                   cnt_d   = cnt_q + 32'd1;
      end
      S_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          dds_start_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_POWER_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q     <= S_POWER_WAIT;
      cnt_q       <= 32'd0;
      retry_q     <= '0;
      step_q      <= 4'd0;
      wr_req_q    <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_fail_q  <= 1'b0;
      dds_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      step_q      <= step_d;
      wr_req_q    <= wr_req_d;
      cfg_done_q  <= cfg_done_d;
      cfg_fail_q  <= cfg_fail_d;
      dds_start_q <= dds_start_d;
    end
  end

  assign WR_REQ    = wr_req_q;
  assign WR_SLAVE  = SLAVE_ADDR;
  assign WR_REG    = entry_active ? entry[15:8] : 8'h00;
  assign WR_DATA   = entry_active ? entry[7:0]  : 8'h00;
  assign STEP      = step_q;
  assign CFG_DONE  = cfg_done_q;
  assign CFG_FAIL  = cfg_fail_q;
  assign DDS_START = dds_start_q;

endmodule

// File: tb/tb_osc_cfg_sequencer.sv
// Directed bench for osc_cfg_sequencer: an I2C engine model answers each request from a
// response plan, and a scoreboard checks every request against the expected entry and cycle.
module tb_osc_cfg_sequencer;

  localparam int P_POWER  = 10;
  localparam int P_SETTLE = 20;
  localparam int P_GAP    = 8;
  localparam int P_TMO    = 30;
  localparam int K_DONE   = 0;
  localparam int K_NACK   = 1;
  localparam int K_SILENT = 2;

  typedef struct { int idx; int cyc; } exp_t;
  typedef struct { int kind; int dly; } plan_t;

  logic       clk;
  logic       RESET;
  logic       WR_REQ;
  logic [6:0] WR_SLAVE;
  logic [7:0] WR_REG;
  logic [7:0] WR_DATA;
  logic       WR_BUSY;
  logic       WR_DONE;
  logic       WR_NACK;
  logic [3:0] STEP;
  logic       CFG_DONE;
  logic       CFG_FAIL;
  logic       DDS_START;
  logic       eng_done, eng_nack, stray_done;

  logic [7:0] tbl_reg [11] = '{8'h84, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h84, 8'h84};
  logic [7:0] tbl_dat [11] = '{8'h00, 8'h33, 8'hE4, 8'hD1, 8'hDF, 8'h96, 8'h08, 8'h1E, 8'h00, 8'h01, 8'h04};

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int cyc = 0;
  int req_count = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int rel = 0;
  int r0 = 0;
  int req_base = 0;

  assign WR_DONE = eng_done | stray_done;
  assign WR_NACK = eng_nack;

  osc_cfg_sequencer #(
    .POWER_ON_DELAY(P_POWER), .SETTLE_DELAY(P_SETTLE), .RETRY_GAP(P_GAP),
    .MAX_RETRY(3), .RESP_TIMEOUT(P_TMO), .SLAVE_ADDR(7'h55)
  ) dut (
    .CLOCK_IN(clk), .RESET(RESET), .WR_REQ(WR_REQ), .WR_SLAVE(WR_SLAVE),
    .WR_REG(WR_REG), .WR_DATA(WR_DATA), .WR_BUSY(WR_BUSY), .WR_DONE(WR_DONE),
    .WR_NACK(WR_NACK), .STEP(STEP), .CFG_DONE(CFG_DONE), .CFG_FAIL(CFG_FAIL),
    .DDS_START(DDS_START)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_req(input int idx, input int kind, input int ecyc);
    plan_t p;
    exp_t  e;
    p.kind = kind;
    p.dly  = 5;
    e.idx  = idx;
    e.cyc  = ecyc;
    plan_q.push_back(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic assert_rst();
    RESET = 1'b1;
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst();
    RESET    = 1'b0;
    rel      = cyc;
    req_base = req_count;
  endtask

  task automatic pulse_stray();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
  endtask

  // Engine model: answers each request according to the next plan entry.
  initial begin
    plan_t p;
    eng_done = 1'b0;
    eng_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (WR_REQ === 1'b1) begin
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else begin p.kind = K_DONE; p.dly = 5; end
        if (p.kind != K_SILENT) begin
          repeat (p.dly) @(negedge clk);
          if (p.kind == K_DONE) eng_done = 1'b1;
          else                  eng_nack = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
          eng_nack = 1'b0;
        end
      end
    end
  end

  // Scoreboard side: every request is compared against the next expected entry.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (WR_REQ === 1'b1) begin
        req_count++;
        t = $sformatf("req%0d", req_count);
        check({t, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("req %0d cycle %0d step %0d reg %02h data %02h (expect entry %0d)",
                   req_count, cyc, STEP, WR_REG, WR_DATA, e.idx);
          check({t, "_slave"}, 32'(WR_SLAVE), 32'h55);
          check({t, "_step"},  32'(STEP),     32'(e.idx));
          check({t, "_reg"},   32'(WR_REG),   32'(tbl_reg[e.idx]));
          check({t, "_data"},  32'(WR_DATA),  32'(tbl_dat[e.idx]));
          if (e.cyc >= 0) check({t, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    RESET      = 1'b1;
    WR_BUSY    = 1'b0;
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_req",    32'(WR_REQ),    32'd0);
    check("rst_wr_reg",    32'(WR_REG),    32'd0);
    check("rst_wr_data",   32'(WR_DATA),   32'd0);
    check("rst_step",      32'(STEP),      32'd0);
    check("rst_cfg_done",  32'(CFG_DONE),  32'd0);
    check("rst_cfg_fail",  32'(CFG_FAIL),  32'd0);
    check("rst_dds_start", 32'(DDS_START), 32'd0);

    // 1: clean run, DONE 5 cycles after each request
    release_rst();
    r0 = rel + P_POWER + 1;
    for (int k = 0; k < 11; k++) push_req(k, K_DONE, r0 + 7 * k);
    wait_cyc(r0 + 75);
    check("s1_done_early", 32'(CFG_DONE), 32'd0);
    wait_cyc(r0 + 76);
    check("s1_cfg_done", 32'(CFG_DONE), 32'd1);
    check("s1_step11",   32'(STEP),     32'd11);
    check("s1_cfg_fail", 32'(CFG_FAIL), 32'd0);
    wait_cyc(r0 + 76 + P_SETTLE - 1);
    check("s1_dds_early", 32'(DDS_START), 32'd0);
    wait_cyc(r0 + 76 + P_SETTLE);
    check("s1_dds_start", 32'(DDS_START), 32'd1);
    check("s1_all_reqs",  32'(exp_q.size()), 32'd0);
    check("s1_req_count", 32'(req_count - req_base), 32'd11);

    // 2: NACK on first attempt of entry 3, stray DONEs in POWER_WAIT and GAP
    assert_rst();
    release_rst();
    r0 = rel + P_POWER + 1;
    for (int k = 0; k < 3; k++) push_req(k, K_DONE, r0 + 7 * k);
    push_req(3, K_NACK, r0 + 21);
    push_req(3, K_DONE, r0 + 21 + 6 + P_GAP + 1);
    for (int i = 4; i < 11; i++) push_req(i, K_DONE, r0 + 36 + 7 * (i - 3));
    wait_cyc(rel + 3);
    pulse_stray();
    wait_cyc(r0 + 30);
    pulse_stray();
    wait_cyc(r0 + 91);
    check("s2_cfg_done", 32'(CFG_DONE), 32'd1);
    check("s2_cfg_fail", 32'(CFG_FAIL), 32'd0);
    check("s2_step11",   32'(STEP),     32'd11);
    check("s2_all_reqs", 32'(exp_q.size()), 32'd0);

    // 3: entry 5 NACKs on every attempt
    assert_rst();
    release_rst();
    r0 = rel + P_POWER + 1;
    for (int k = 0; k < 5; k++) push_req(k, K_DONE, r0 + 7 * k);
    for (int a = 0; a < 4; a++) push_req(5, K_NACK, r0 + 35 + 15 * a);
    wait_cyc(r0 + 85);
    check("s3_fail_early", 32'(CFG_FAIL), 32'd0);
    wait_cyc(r0 + 86);
    check("s3_cfg_fail", 32'(CFG_FAIL), 32'd1);
    check("s3_step5",    32'(STEP),     32'd5);
    wait_cyc(r0 + 286);
    check("s3_req_count", 32'(req_count - req_base), 32'd9);
    check("s3_dds_low",   32'(DDS_START), 32'd0);
    check("s3_done_low",  32'(CFG_DONE),  32'd0);
    check("s3_step_hold", 32'(STEP),      32'd5);
    check("s3_all_reqs",  32'(exp_q.size()), 32'd0);

    // 4: no response to entry 0 -> timeout counts as a failure, retry succeeds
    assert_rst();
    release_rst();
    r0 = rel + P_POWER + 1;
    push_req(0, K_SILENT, r0);
    push_req(0, K_DONE, r0 + P_TMO + P_GAP + 1);
    for (int i = 1; i < 11; i++) push_req(i, K_DONE, r0 + 39 + 7 * i);
    wait_cyc(r0 + 115);
    check("s4_cfg_done", 32'(CFG_DONE), 32'd1);
    check("s4_cfg_fail", 32'(CFG_FAIL), 32'd0);
    wait_cyc(r0 + 115 + P_SETTLE - 1);
    check("s4_dds_early", 32'(DDS_START), 32'd0);
    wait_cyc(r0 + 115 + P_SETTLE);
    check("s4_dds_start", 32'(DDS_START), 32'd1);
    check("s4_all_reqs",  32'(exp_q.size()), 32'd0);

    // 5: WR_BUSY held for 50 cycles at ISSUE, stray DONE in POWER_WAIT
    assert_rst();
    release_rst();
    WR_BUSY = 1'b1;
    r0 = rel + P_POWER + 50 + 1;
    for (int k = 0; k < 11; k++) push_req(k, K_DONE, r0 + 7 * k);
    wait_cyc(rel + 4);
    pulse_stray();
    wait_cyc(rel + 40);
    check("s5_busy_step",   32'(STEP),   32'd0);
    check("s5_busy_no_req", 32'(req_count - req_base), 32'd0);
    wait_cyc(rel + P_POWER + 50);
    WR_BUSY = 1'b0;
    wait_cyc(r0 + 76);
    check("s5_cfg_done", 32'(CFG_DONE), 32'd1);
    check("s5_all_reqs", 32'(exp_q.size()), 32'd0);

    // 6: one-cycle reset while waiting for the response of entry 7
    assert_rst();
    release_rst();
    r0 = rel + P_POWER + 1;
    for (int k = 0; k < 8; k++) push_req(k, K_DONE, r0 + 7 * k);
    wait_cyc(r0 + 51);
    RESET = 1'b1;
    @(negedge clk);
    release_rst();
    check("s6_rst_step",    32'(STEP),     32'd0);
    check("s6_rst_wr_req",  32'(WR_REQ),   32'd0);
    check("s6_rst_wr_reg",  32'(WR_REG),   32'd0);
    check("s6_rst_wr_data", 32'(WR_DATA),  32'd0);
    check("s6_rst_done",    32'(CFG_DONE), 32'd0);
    check("s6_pre_reqs",    32'(exp_q.size()), 32'd0);
    r0 = rel + P_POWER + 1;
    for (int k = 0; k < 11; k++) push_req(k, K_DONE, r0 + 7 * k);
    wait_cyc(rel + 8);
    check("s6_late_done_ignored", 32'(STEP), 32'd0);
    wait_cyc(r0 + 76);
    check("s6_cfg_done", 32'(CFG_DONE), 32'd1);
    check("s6_step11",   32'(STEP),     32'd11);
    wait_cyc(r0 + 76 + P_SETTLE);
    check("s6_dds_start", 32'(DDS_START), 32'd1);
    check("s6_all_reqs",  32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
